button_debounce_multi: RTL



---
 rtl/btn_pkg.sv | 21 ++
 rtl/button_debounce_channel.sv | 146 ++++++++++++++
 rtl/button_debounce_multi.sv | 40 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and width helpers for the multi-channel button debouncer.
// Imported by the per-channel filter and the top-level wrapper.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      HELD,
      RELEASING
   } btn_state_e;

   // Bits needed to hold every value 0..max_val without wrapping.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One debounced button: input synchroniser, symmetric press/release filter FSM,
// and auto-repeat timer that runs while the debounced level is high.
module button_debounce_channel
   import btn_pkg::*;
#(
   parameter int WAIT_CLOCKS   = 1_000_000,
   parameter int SYNC_STAGES   = 2,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   input  logic i_repeat_en,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_repeat
);

   localparam int CNT_W = cnt_width(WAIT_CLOCKS);
   localparam int RPT_W = cnt_width(max_of(REPEAT_DELAY, REPEAT_PERIOD));

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CLOCKS - 1);
   localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RPT_W-1:0] rcnt_q, rcnt_d;
   logic             period_q, period_d;   // 0: waiting out REPEAT_DELAY, 1: REPEAT_PERIOD
   logic             level_d, press_d, release_d, repeat_d;
   logic             active;

   // NOTE: the synchroniser chain is reset along with the FSM, so a button held
   // through reset must refill the chain and be re-debounced before it is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every signal gets a default before the case, so no path through
      // this block leaves a value unassigned and no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = o_level;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      rcnt_d    = '0;
      period_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (s) begin
               state_d = ARMING;
               cnt_d   = CNT_W'(1);
            end
         end
         ARMING: begin
            if (!s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (!s) begin
               state_d = RELEASING;
               cnt_d   = CNT_W'(1);
            end
         end
         RELEASING: begin
            if (s) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase

      // A repeat that falls due on the release edge is dropped with the counter.
      active = (state_q == HELD || state_q == RELEASING) && (state_d != IDLE);
      if (active && i_repeat_en) begin
         if (rcnt_q == (period_q ? PER_LAST : DLY_LAST)) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
            period_d = 1'b1;
         end else begin
            rcnt_d   = rcnt_q + RPT_W'(1);
            period_d = period_q;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rcnt_q    <= '0;
         period_q  <= 1'b0;
         o_level   <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_repeat  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rcnt_q    <= rcnt_d;
         period_q  <= period_d;
         o_level   <= level_d;
         o_press   <= press_d;
         o_release <= release_d;
         o_repeat  <= repeat_d;
      end
   end

endmodule

// File: rtl/button_debounce_multi.sv
// N_BTN independent debounced buttons with press/release pulses and a shared
// auto-repeat enable fanned out to every channel.
module button_debounce_multi
   import btn_pkg::*;
#(
   parameter int N_BTN         = 4,
   parameter int WAIT_CLOCKS   = 1_000_000,
   parameter int SYNC_STAGES   = 2,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] i_btn,
   input  logic             i_repeat_en,
   output logic [N_BTN-1:0] o_level,
   output logic [N_BTN-1:0] o_press,
   output logic [N_BTN-1:0] o_release,
   output logic [N_BTN-1:0] o_repeat
);

   for (genvar k = 0; k < N_BTN; k++) begin : g_ch
      button_debounce_channel #(
         .WAIT_CLOCKS   (WAIT_CLOCKS),
         .SYNC_STAGES   (SYNC_STAGES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .i_btn       (i_btn[k]),
         .i_repeat_en (i_repeat_en),
         .o_level     (o_level[k]),
         .o_press     (o_press[k]),
         .o_release   (o_release[k]),
         .o_repeat    (o_repeat[k])
      );
   end

endmodule
